// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the shared SRAM port.
// Latency: none, wires only.
// Backpressure: write requests are level-held until wr_ack; video has no stall path.
interface sram_arbiter_if #(
   parameter int AW = 19,
   parameter int DW = 16
) ();
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_valid;
   logic [DW-1:0] vid_data;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          clear_start;
   logic          clear_busy;
   logic          clear_done;
   logic          mem_wren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_d;
   logic [DW-1:0] mem_q;

   // Arbiter side
   modport slave (
      input  vid_req, vid_addr, wr_req, wr_addr, wr_data, clear_start, mem_q,
      output vid_valid, vid_data, wr_ack, clear_busy, clear_done,
             mem_wren, mem_addr, mem_d
   );

   // Requester / SRAM side
   modport master (
      output vid_req, vid_addr, wr_req, wr_addr, wr_data, clear_start, mem_q,
      input  vid_valid, vid_data, wr_ack, clear_busy, clear_done,
             mem_wren, mem_addr, mem_d
   );
endinterface

// File: rtl/sram_arbiter.sv
// Time-slot arbiter for the shared SRAM port: video reads, bulk clear, pixel writes.
// Latency: commands registered (1 edge); read data returned READ_LAT edges after issue.
// Backpressure: wr_req held until wr_ack; stalled throughout a clear and in busy video slots.
module sram_arbiter #(
   parameter int             AW          = 19,
   parameter int             DW          = 16,
   parameter int             CLEAR_WORDS = 416800,
   parameter logic [DW-1:0]  CLEAR_VAL   = '0,
   parameter int             READ_LAT    = 2     // 1..4
) (
   input  logic            clk,
   input  logic            rst_n,
   sram_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_RUN} state_e;

   localparam logic [AW-1:0] CLR_LAST = AW'(CLEAR_WORDS - 1);

   state_e                state_q, state_d;
   logic                  phase_q, phase_d;
   logic [AW-1:0]         clr_addr_q, clr_addr_d;
   logic [READ_LAT-1:0]   tag_q, tag_d;
   logic                  mem_wren_q, mem_wren_d;
   logic [AW-1:0]         mem_addr_q, mem_addr_d;
   logic [DW-1:0]         mem_d_q, mem_d_d;
   logic                  vid_valid_q, vid_valid_d;
   logic [DW-1:0]         vid_data_q, vid_data_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  clear_busy_q, clear_busy_d;
   logic                  clear_done_q, clear_done_d;
   logic                  slot_read;

   // Slot selection, clear sequencing and read-tag pipeline
   always_comb begin
      state_d      = state_q;
      phase_d      = ~phase_q;
      clr_addr_d   = clr_addr_q;
      mem_wren_d   = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_d_d      = mem_d_q;
      wr_ack_d     = 1'b0;
      clear_done_d = 1'b0;
      tag_d        = '0;
      slot_read    = (phase_q == 1'b0) && bus.vid_req;

      if (slot_read) begin
         mem_addr_d = bus.vid_addr;
      end else if (state_q == ST_CLEAR) begin
         mem_wren_d = 1'b1;
         mem_addr_d = clr_addr_q;
         mem_d_d    = CLEAR_VAL;
         if (clr_addr_q == CLR_LAST) begin
            state_d      = ST_RUN;
            clear_done_d = 1'b1;
         end else begin
            clr_addr_d = clr_addr_q + AW'(1);
         end
      end else if (bus.wr_req && !wr_ack_q) begin
         // Requester sees the ack only during the following cycle, so a request
         // still high then is the one just served, not a new one.
         mem_wren_d = 1'b1;
         mem_addr_d = bus.wr_addr;
         mem_d_d    = bus.wr_data;
         wr_ack_d   = 1'b1;
      end

      if ((state_q != ST_CLEAR) && bus.clear_start) begin
         state_d    = ST_CLEAR;
         clr_addr_d = '0;
      end
      clear_busy_d = (state_d == ST_CLEAR);

      tag_d[0] = slot_read;
      for (int i = 1; i < READ_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      vid_valid_d = tag_q[READ_LAT-1];
      vid_data_d  = tag_q[READ_LAT-1] ? bus.mem_q : vid_data_q;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= 1'b0;
         clr_addr_q   <= '0;
         tag_q        <= '0;
         mem_wren_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_d_q      <= '0;
         vid_valid_q  <= 1'b0;
         vid_data_q   <= '0;
         wr_ack_q     <= 1'b0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         clr_addr_q   <= clr_addr_d;
         tag_q        <= tag_d;
         mem_wren_q   <= mem_wren_d;
         mem_addr_q   <= mem_addr_d;
         mem_d_q      <= mem_d_d;
         vid_valid_q  <= vid_valid_d;
         vid_data_q   <= vid_data_d;
         wr_ack_q     <= wr_ack_d;
         clear_busy_q <= clear_busy_d;
         clear_done_q <= clear_done_d;
      end
   end

   assign bus.mem_wren   = mem_wren_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_d      = mem_d_q;
   assign bus.vid_valid  = vid_valid_q;
   assign bus.vid_data   = vid_data_q;
   assign bus.wr_ack     = wr_ack_q;
   assign bus.clear_busy = clear_busy_q;
   assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a one-stage-registered SRAM model.
// Latency: model gives READ_LAT=2 from command edge.
// Backpressure: bench requester drops wr_req in the ack cycle.
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   vec = 0;
   int   miss = 0;
   int   edge_n = 0;

   sram_arbiter_if #(.AW(19), .DW(16)) bus ();

   sram_arbiter #(
      .AW(19), .DW(16), .CLEAR_WORDS(16), .CLEAR_VAL(16'hA5A5), .READ_LAT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   // SRAM model: q registered one edge after the address appears
   logic [15:0] mem [0:255];
   logic        mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h1000 + 16'(i);
         mem_init <= 1'b1;
      end else begin
         bus.mem_q <= mem[bus.mem_addr[7:0]];
         if (bus.mem_wren) mem[bus.mem_addr[7:0]] <= bus.mem_d;
      end
   end

   function automatic logic [15:0] pat(input int a);
      return 16'h1000 + 16'(a);
   endfunction

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic align0();
      if (edge_n % 2 == 1) tick();
   endtask

   task automatic test_reset();
      bus.vid_req = 0; bus.vid_addr = '0; bus.wr_req = 0; bus.wr_addr = '0;
      bus.wr_data = '0; bus.clear_start = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec++; if (bus.mem_wren !== 1'b0) begin miss++; $display("FAIL reset mem_wren got %b exp 0", bus.mem_wren); end
      vec++; if (bus.mem_addr !== 19'd0) begin miss++; $display("FAIL reset mem_addr got %h exp 0", bus.mem_addr); end
      vec++; if (bus.mem_d !== 16'd0) begin miss++; $display("FAIL reset mem_d got %h exp 0", bus.mem_d); end
      vec++; if (bus.vid_valid !== 1'b0) begin miss++; $display("FAIL reset vid_valid got %b exp 0", bus.vid_valid); end
      vec++; if (bus.vid_data !== 16'd0) begin miss++; $display("FAIL reset vid_data got %h exp 0", bus.vid_data); end
      vec++; if (bus.wr_ack !== 1'b0) begin miss++; $display("FAIL reset wr_ack got %b exp 0", bus.wr_ack); end
      vec++; if (bus.clear_busy !== 1'b0) begin miss++; $display("FAIL reset clear_busy got %b exp 0", bus.clear_busy); end
      vec++; if (bus.clear_done !== 1'b0) begin miss++; $display("FAIL reset clear_done got %b exp 0", bus.clear_done); end
      @(negedge clk) rst_n = 1'b1;
      edge_n = 0;
   endtask

   task automatic test_video_stream();
      logic          have_prev = 0;
      logic [18:0]   prev_a = '0;
      align0();
      for (int i = 0; i < 18; i++) begin
         logic        p0;
         logic [18:0] a;
         p0 = (edge_n % 2 == 0);
         a  = 19'(32 + i / 2);
         bus.vid_req  = (i < 16);
         bus.vid_addr = a;
         tick();
         if (p0) begin
            vec++;
            if (bus.vid_valid !== have_prev) begin miss++; $display("FAIL vid_valid edge %0d got %b exp %b", i, bus.vid_valid, have_prev); end
            if (have_prev) begin
               vec++;
               if (bus.vid_data !== pat(int'(prev_a))) begin miss++; $display("FAIL vid_data edge %0d got %h exp %h", i, bus.vid_data, pat(int'(prev_a))); end
            end
            if (i < 16) begin
               vec++;
               if (bus.mem_wren !== 1'b0 || bus.mem_addr !== a) begin miss++; $display("FAIL vid_issue edge %0d got wren=%b addr=%h exp wren=0 addr=%h", i, bus.mem_wren, bus.mem_addr, a); end
            end
            have_prev = (i < 16);
            prev_a    = a;
         end else begin
            vec++;
            if (bus.vid_valid !== 1'b0) begin miss++; $display("FAIL vid_valid_odd edge %0d got %b exp 0", i, bus.vid_valid); end
         end
      end
      bus.vid_req = 0;
   endtask

   task automatic test_clear_idle();
      int done_cnt = 0;
      bus.vid_req = 0;
      bus.clear_start = 1;
      tick();
      bus.clear_start = 0;
      vec++; if (bus.clear_busy !== 1'b1) begin miss++; $display("FAIL clr_busy_rise got %b exp 1", bus.clear_busy); end
      for (int k = 0; k < 16; k++) begin
         tick();
         vec++;
         if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 19'(k) || bus.mem_d !== 16'hA5A5) begin
            miss++; $display("FAIL clr_write %0d got wren=%b addr=%h d=%h exp 1/%h/a5a5", k, bus.mem_wren, bus.mem_addr, bus.mem_d, k);
         end
         if (bus.clear_done) done_cnt++;
         vec++;
         if (bus.clear_busy !== (k != 15)) begin miss++; $display("FAIL clr_busy %0d got %b exp %b", k, bus.clear_busy, k != 15); end
      end
      vec++; if (bus.clear_done !== 1'b1) begin miss++; $display("FAIL clr_done_last got %b exp 1", bus.clear_done); end
      tick();
      if (bus.clear_done) done_cnt++;
      vec++; if (done_cnt !== 1) begin miss++; $display("FAIL clr_done_count got %0d exp 1", done_cnt); end
      vec++; if (bus.mem_wren !== 1'b0) begin miss++; $display("FAIL clr_after_wren got %b exp 0", bus.mem_wren); end
      for (int k = 0; k < 16; k++) begin
         vec++;
         if (mem[k] !== 16'hA5A5) begin miss++; $display("FAIL clr_mem[%0d] got %h exp a5a5", k, mem[k]); end
      end
   endtask

   task automatic test_clear_with_video();
      logic        have_prev = 0;
      logic [18:0] prev_a = '0;
      align0();
      for (int i = 0; i < 34; i++) begin
         logic        p0;
         logic [18:0] a;
         p0 = (edge_n % 2 == 0);
         a  = 19'(40 + i / 2);
         bus.vid_req     = (i < 32);
         bus.vid_addr    = a;
         bus.clear_start = (i == 0);
         tick();
         bus.clear_start = 0;
         vec++;
         if (bus.clear_done !== (i == 31)) begin miss++; $display("FAIL cv_done edge %0d got %b exp %b", i, bus.clear_done, i == 31); end
         if (p0) begin
            vec++;
            if (bus.vid_valid !== have_prev) begin miss++; $display("FAIL cv_vid_valid edge %0d got %b exp %b", i, bus.vid_valid, have_prev); end
            if (have_prev && bus.vid_data !== pat(int'(prev_a))) begin miss++; $display("FAIL cv_vid_data edge %0d got %h exp %h", i, bus.vid_data, pat(int'(prev_a))); end
            if (i < 32) begin
               vec++;
               if (bus.mem_wren !== 1'b0 || bus.mem_addr !== a) begin miss++; $display("FAIL cv_read edge %0d got wren=%b addr=%h exp 0/%h", i, bus.mem_wren, bus.mem_addr, a); end
            end
            have_prev = (i < 32);
            prev_a    = a;
         end else if (i < 32) begin
            vec++;
            if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 19'(i / 2) || bus.mem_d !== 16'hA5A5) begin
               miss++; $display("FAIL cv_clr edge %0d got wren=%b addr=%h d=%h exp 1/%h/a5a5", i, bus.mem_wren, bus.mem_addr, bus.mem_d, i / 2);
            end
         end else begin
            vec++;
            if (bus.mem_wren !== 1'b0) begin miss++; $display("FAIL cv_idle edge %0d got wren=%b exp 0", i, bus.mem_wren); end
         end
         if (i == 30) begin
            vec++; if (bus.clear_busy !== 1'b1) begin miss++; $display("FAIL cv_busy_hold got %b exp 1", bus.clear_busy); end
         end
         if (i == 31) begin
            vec++; if (bus.clear_busy !== 1'b0) begin miss++; $display("FAIL cv_busy_fall got %b exp 0", bus.clear_busy); end
         end
      end
      bus.vid_req = 0;
   endtask

   task automatic test_write_during_clear();
      int ack_cnt = 0;
      int ack_edge = -1;
      int done_edge = -1;
      bus.vid_req = 0;
      bus.clear_start = 1;
      tick();
      bus.clear_start = 0;
      bus.wr_req = 1; bus.wr_addr = 19'd100; bus.wr_data = 16'd350;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.clear_done) done_edge = i;
         if (bus.wr_ack) begin
            ack_cnt++;
            ack_edge = i;
            bus.wr_req = 0;
            vec++;
            if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 19'd100 || bus.mem_d !== 16'd350) begin
               miss++; $display("FAIL wdc_cmd got wren=%b addr=%h d=%h exp 1/64/15e", bus.mem_wren, bus.mem_addr, bus.mem_d);
            end
         end
      end
      bus.wr_req = 0;
      vec++; if (done_edge !== 15) begin miss++; $display("FAIL wdc_done_edge got %0d exp 15", done_edge); end
      vec++; if (ack_edge !== 16) begin miss++; $display("FAIL wdc_ack_edge got %0d exp 16", ack_edge); end
      vec++; if (ack_cnt !== 1) begin miss++; $display("FAIL wdc_ack_count got %0d exp 1", ack_cnt); end
      vec++; if (mem[100] !== 16'd350) begin miss++; $display("FAIL wdc_mem100 got %h exp 015e", mem[100]); end
   endtask

   task automatic test_back_to_back();
      int   wcnt = 0;
      logic just_acked = 0;
      align0();
      bus.vid_addr = 19'd48;
      for (int i = 0; i < 20; i++) begin
         logic p0, vreq, req, exp_ack;
         p0   = (edge_n % 2 == 0);
         vreq = (i % 4 == 0);
         req  = (i >= 2) && (wcnt < 3) && !just_acked;
         bus.vid_req = vreq;
         bus.wr_req  = req;
         bus.wr_addr = 19'(101 + wcnt);
         bus.wr_data = 16'h1111 * 16'(wcnt + 1);
         exp_ack = req && !(p0 && vreq);
         tick();
         just_acked = 0;
         vec++;
         if (bus.wr_ack !== exp_ack) begin miss++; $display("FAIL b2b_ack edge %0d got %b exp %b", i, bus.wr_ack, exp_ack); end
         if (p0 && vreq) begin
            vec++;
            if (bus.mem_wren !== 1'b0) begin miss++; $display("FAIL b2b_vid_slot edge %0d got wren=%b exp 0", i, bus.mem_wren); end
         end
         if (bus.wr_ack) begin
            vec++;
            if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 19'(101 + wcnt) || bus.mem_d !== 16'h1111 * 16'(wcnt + 1)) begin
               miss++; $display("FAIL b2b_cmd %0d got wren=%b addr=%h d=%h", wcnt, bus.mem_wren, bus.mem_addr, bus.mem_d);
            end
            wcnt++;
            just_acked = 1;
            bus.wr_req = 0;
         end
      end
      bus.wr_req = 0; bus.vid_req = 0;
      vec++; if (wcnt !== 3) begin miss++; $display("FAIL b2b_count got %0d exp 3", wcnt); end
      vec++; if (mem[101] !== 16'h1111 || mem[102] !== 16'h2222 || mem[103] !== 16'h3333) begin
         miss++; $display("FAIL b2b_mem got %h %h %h exp 1111 2222 3333", mem[101], mem[102], mem[103]);
      end
   endtask

   task automatic test_reset_mid_clear();
      int bad = 0;
      align0();
      bus.vid_req = 1; bus.vid_addr = 19'd60; bus.clear_start = 1;
      tick();
      bus.clear_start = 0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      vec++;
      if ({bus.mem_wren, bus.mem_addr, bus.mem_d, bus.vid_valid, bus.vid_data,
           bus.wr_ack, bus.clear_busy, bus.clear_done} !== 57'd0) begin
         miss++; $display("FAIL rst_async got wren=%b addr=%h d=%h vv=%b vd=%h ack=%b busy=%b done=%b exp all 0",
                          bus.mem_wren, bus.mem_addr, bus.mem_d, bus.vid_valid, bus.vid_data,
                          bus.wr_ack, bus.clear_busy, bus.clear_done);
      end
      bus.vid_req = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      edge_n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.vid_valid || bus.clear_done || bus.clear_busy || bus.mem_wren) bad++;
      end
      vec++; if (bad !== 0) begin miss++; $display("FAIL rst_after_release got %0d active edges exp 0", bad); end
   endtask

   initial begin
      test_reset();
      test_video_stream();
      test_clear_idle();
      test_clear_with_video();
      test_write_during_clear();
      test_back_to_back();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
